// File: rtl/processor_program_feeder_if.sv
// Bundles the loader, processor (DIN/Run/Done) and status signals of the program feeder.
// master is the feeder's view; slave is the loader/processor side.
interface processor_program_feeder_if #(
  parameter int AW = 5,
  parameter int CW = 8
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          start;
  logic [AW-1:0] last_addr;
  logic          Done;
  logic [15:0]   DIN;
  logic          Run;
  logic [AW-1:0] pc;
  logic          busy;
  logic          finished;
  logic          error;
  logic [1:0]    err_code;
  logic [CW-1:0] retired;

  modport master (
    input  prog_we, prog_addr, prog_data, start, last_addr, Done,
    output DIN, Run, pc, busy, finished, error, err_code, retired
  );

  modport slave (
    output prog_we, prog_addr, prog_data, start, last_addr, Done,
    input  DIN, Run, pc, busy, finished, error, err_code, retired
  );
endinterface

// File: rtl/processor_program_feeder.sv
// Feeds a loadable program to a multicycle processor over DIN/Run/Done, one instruction
// at a time, with a Done watchdog, truncated-mvi detection and a saturating retire count.
module processor_program_feeder #(
  parameter int AW      = 5,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input logic                         Clock,
  input logic                         Resetn,
  processor_program_feeder_if.master  bus
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] PC_ONE   = AW'(1);
  localparam logic [AW-1:0] PC_TWO   = AW'(2);
  localparam logic [AW-1:0] PC_ZERO  = AW'(0);
  localparam logic [WW-1:0] WD_ONE   = WW'(1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT - 1);
  localparam logic [CW-1:0] RET_ONE  = CW'(1);
  localparam logic [CW-1:0] RET_MAX  = {CW{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    EXEC  = 3'd2,
    FIN   = 3'd3,
    ERR   = 3'd4
  } state_t;

  function automatic logic is_mvi(input logic [15:0] word);
    return word[8:6] == 3'b001;
  endfunction

  logic [15:0]   mem_r [DEPTH];
  state_t        state_r, state_n_s;
  logic [15:0]   din_r, din_n_s;
  logic [AW-1:0] pc_r, pc_n_s;
  logic [AW-1:0] last_r, last_n_s;
  logic [CW-1:0] ret_r, ret_n_s;
  logic [1:0]    ec_r, ec_n_s;
  logic [WW-1:0] wdog_r, wdog_n_s;

  logic          halted_s;
  logic          trunc_s;
  logic [AW-1:0] len_s;
  logic [AW-1:0] pc_adv_s;
  logic [AW-1:0] last_word_s;
  logic [15:0]   start_word_s;

  assign halted_s    = (state_r == IDLE) || (state_r == FIN) || (state_r == ERR);
  assign trunc_s     = is_mvi(din_r) && (pc_r == last_r);
  // Memory is frozen while running, so the opcode can be re-read at pc during EXEC.
  assign len_s       = is_mvi(mem_r[pc_r]) ? PC_TWO : PC_ONE;
  assign pc_adv_s    = pc_r + len_s;
  assign last_word_s = pc_adv_s - PC_ONE;
  // A write to word 0 on the start edge must be seen by the run it launches.
  assign start_word_s = (bus.prog_we && (bus.prog_addr == PC_ZERO)) ? bus.prog_data : mem_r[0];

  // Program memory write port, open only while no program is running.
  always_ff @(posedge Clock) begin
    if (bus.prog_we && halted_s) begin
      mem_r[bus.prog_addr] <= bus.prog_data;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_r <= IDLE;
      din_r   <= 16'h0000;
      pc_r    <= PC_ZERO;
      last_r  <= PC_ZERO;
      ret_r   <= {CW{1'b0}};
      ec_r    <= 2'b00;
      wdog_r  <= {WW{1'b0}};
    end else begin
      state_r <= state_n_s;
      din_r   <= din_n_s;
      pc_r    <= pc_n_s;
      last_r  <= last_n_s;
      ret_r   <= ret_n_s;
      ec_r    <= ec_n_s;
      wdog_r  <= wdog_n_s;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_n_s = state_r;
    din_n_s   = din_r;
    pc_n_s    = pc_r;
    last_n_s  = last_r;
    ret_n_s   = ret_r;
    ec_n_s    = ec_r;
    wdog_n_s  = wdog_r;
    case (state_r)
      IDLE, FIN, ERR: begin
        if (bus.start) begin
          state_n_s = ISSUE;
          pc_n_s    = PC_ZERO;
          din_n_s   = start_word_s;
          ret_n_s   = {CW{1'b0}};
          ec_n_s    = 2'b00;
          last_n_s  = bus.last_addr;
        end else begin
          state_n_s = state_r;
        end
      end
      ISSUE: begin
        if (trunc_s) begin
          state_n_s = ERR;
          ec_n_s    = 2'b10;
        end else begin
          if (is_mvi(din_r)) begin
            din_n_s = mem_r[pc_r + PC_ONE];
          end else begin
            din_n_s = din_r;
          end
          wdog_n_s  = {WW{1'b0}};
          state_n_s = EXEC;
        end
      end
      EXEC: begin
        if (bus.Done) begin
          ret_n_s = (ret_r == RET_MAX) ? ret_r : ret_r + RET_ONE;
          if (last_word_s == last_r) begin
            state_n_s = FIN;
          end else begin
            pc_n_s    = pc_adv_s;
            din_n_s   = mem_r[pc_adv_s];
            state_n_s = ISSUE;
          end
        end else if (wdog_r == WD_LIMIT) begin
          wdog_n_s  = wdog_r + WD_ONE;
          ec_n_s    = 2'b01;
          state_n_s = ERR;
        end else begin
          wdog_n_s = wdog_r + WD_ONE;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  assign bus.DIN      = din_r;
  assign bus.Run      = (state_r == ISSUE) && !trunc_s;
  assign bus.pc       = pc_r;
  assign bus.busy     = (state_r == ISSUE) || (state_r == EXEC);
  assign bus.finished = (state_r == FIN);
  assign bus.error    = (state_r == ERR);
  assign bus.err_code = ec_r;
  assign bus.retired  = ret_r;

endmodule

// File: tb/tb_processor_program_feeder.sv
// Randomized bench for processor_program_feeder: an instruction-level model expands each run
// into a per-cycle expected trace (also scheduling Done), compared every cycle against two DUTs.
module tb_processor_program_feeder;

  localparam int AW      = 5;
  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 15;

  typedef struct {
    bit          run;
    bit          exec;
    logic [15:0] din;
    logic [4:0]  pc;
    bit          busy;
    bit          fin;
    bit          err;
    logic [1:0]  ec;
    int          ret;
    bit          done;
  } cyc_t;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  logic [15:0] mdl_mem [DEPTH];
  cyc_t        trace [$];
  int          lat_q [$];
  logic [15:0] run_dins [$];
  int          run_cyc [$];
  int          err_cyc;
  logic [15:0] din_c2;

  processor_program_feeder_if #(.AW(AW), .CW(8)) bus ();
  processor_program_feeder_if #(.AW(AW), .CW(2)) bus2 ();

  assign bus2.prog_we   = bus.prog_we;
  assign bus2.prog_addr = bus.prog_addr;
  assign bus2.prog_data = bus.prog_data;
  assign bus2.start     = bus.start;
  assign bus2.last_addr = bus.last_addr;
  assign bus2.Done      = bus.Done;

  processor_program_feeder #(.AW(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CW(8)) u_dut (
    .Clock (clk),
    .Resetn(rstn),
    .bus   (bus)
  );

  processor_program_feeder #(.AW(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CW(2)) u_dut_sat (
    .Clock (clk),
    .Resetn(rstn),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push(input bit run, input bit exec, input logic [15:0] din,
                               input logic [4:0] pc, input bit busy, input bit fin, input bit err,
                               input logic [1:0] ec, input int ret, input bit done);
    cyc_t c;
    c.run = run; c.exec = exec; c.din = din; c.pc = pc; c.busy = busy;
    c.fin = fin; c.err = err; c.ec = ec; c.ret = ret; c.done = done;
    trace.push_back(c);
  endfunction

  function automatic void term(input logic [15:0] din, input logic [4:0] pc, input bit fin,
                               input bit err, input logic [1:0] ec, input int ret);
    for (int j = 0; j < 3; j++) push(1'b0, 1'b0, din, pc, 1'b0, fin, err, ec, ret, 1'b0);
  endfunction

  // Walks the program one instruction at a time and lays out the cycles it must take.
  function automatic void build_trace(input logic [4:0] last);
    logic [4:0]  p;
    logic [15:0] w;
    logic [15:0] ed;
    bit          mvi;
    int          r;
    int          lat;
    int          k;
    p = 5'd0; r = 0; k = 0;
    trace.delete();
    while (k < 100) begin
      w   = mdl_mem[p];
      mvi = (w[8:6] == 3'b001);
      if (mvi && p == last) begin
        push(1'b0, 1'b0, w, p, 1'b1, 1'b0, 1'b0, 2'b00, r, 1'b0);
        term(w, p, 1'b0, 1'b1, 2'b10, r);
        return;
      end
      push(1'b1, 1'b0, w, p, 1'b1, 1'b0, 1'b0, 2'b00, r, 1'b0);
      ed  = mvi ? mdl_mem[5'(p + 5'd1)] : w;
      lat = (k < lat_q.size()) ? lat_q[k] : 1;
      k++;
      if (lat < 1 || lat > TIMEOUT) begin
        for (int j = 0; j < TIMEOUT; j++) push(1'b0, 1'b1, ed, p, 1'b1, 1'b0, 1'b0, 2'b00, r, 1'b0);
        term(ed, p, 1'b0, 1'b1, 2'b01, r);
        return;
      end
      for (int j = 1; j <= lat; j++) push(1'b0, 1'b1, ed, p, 1'b1, 1'b0, 1'b0, 2'b00, r, j == lat);
      r++;
      if (5'(p + (mvi ? 5'd1 : 5'd0)) == last) begin
        term(ed, p, 1'b1, 1'b0, 2'b00, r);
        return;
      end
      p = 5'(p + (mvi ? 5'd2 : 5'd1));
    end
  endfunction

  task automatic check_cycle(input cyc_t c, input int idx);
    string s;
    s = $sformatf("cyc%0d", idx);
    chk({s, "_run"},      32'(bus.Run),      32'(c.run));
    chk({s, "_din"},      32'(bus.DIN),      32'(c.din));
    chk({s, "_pc"},       32'(bus.pc),       32'(c.pc));
    chk({s, "_busy"},     32'(bus.busy),     32'(c.busy));
    chk({s, "_finished"}, 32'(bus.finished), 32'(c.fin));
    chk({s, "_error"},    32'(bus.error),    32'(c.err));
    chk({s, "_err_code"}, 32'(bus.err_code), 32'(c.ec));
    chk({s, "_retired"},  32'(bus.retired),  32'((c.ret > 255) ? 255 : c.ret));
    chk({s, "_retired_cw2"},  32'(bus2.retired),  32'((c.ret > 3) ? 3 : c.ret));
    chk({s, "_finished_cw2"}, 32'(bus2.finished), 32'(c.fin));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_run"},      32'(bus.Run),      32'd0);
    chk({nm, "_din"},      32'(bus.DIN),      32'd0);
    chk({nm, "_pc"},       32'(bus.pc),       32'd0);
    chk({nm, "_busy"},     32'(bus.busy),     32'd0);
    chk({nm, "_finished"}, 32'(bus.finished), 32'd0);
    chk({nm, "_error"},    32'(bus.error),    32'd0);
    chk({nm, "_err_code"}, 32'(bus.err_code), 32'd0);
    chk({nm, "_retired"},  32'(bus.retired),  32'd0);
  endtask

  task automatic load_word(input logic [4:0] a, input logic [15:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    mdl_mem[a]    = d;
    @(posedge clk); #1;
    bus.prog_we   = 1'b0;
  endtask

  // Launches one run and steps through the expected trace, driving Done and noise.
  task automatic run_trace(input logic [4:0] last, input bit noise, input bit wr_busy,
                           input bit wr0, input logic [15:0] w0, input int reset_at);
    if (wr0) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 5'd0;
      bus.prog_data = w0;
      mdl_mem[0]    = w0;
    end
    build_trace(last);
    run_dins.delete();
    run_cyc.delete();
    err_cyc       = -1;
    bus.last_addr = last;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.prog_we   = 1'b0;
    bus.last_addr = 5'($urandom_range(0, 31));
    for (int i = 0; i < trace.size(); i++) begin
      bus.Done = trace[i].done;
      if (noise && !trace[i].exec && $urandom_range(0, 2) == 0) bus.Done = 1'b1;
      if (noise && trace[i].busy && $urandom_range(0, 3) == 0) bus.start = 1'b1;
      if (trace[i].busy && wr_busy) begin
        bus.prog_we   = 1'b1;
        bus.prog_addr = 5'd2;
        bus.prog_data = 16'h0000;
      end else if (noise && trace[i].busy && $urandom_range(0, 3) == 0) begin
        bus.prog_we   = 1'b1;
        bus.prog_addr = 5'($urandom_range(0, 31));
        bus.prog_data = 16'($urandom);
      end
      if (i == reset_at) rstn = 1'b0;
      @(negedge clk);
      check_cycle(trace[i], i + 1);
      if (bus.Run === 1'b1) begin
        run_dins.push_back(bus.DIN);
        run_cyc.push_back(i + 1);
      end
      if (i == 1) din_c2 = bus.DIN;
      if (bus.error === 1'b1 && err_cyc < 0) err_cyc = i + 1;
      @(posedge clk); #1;
      bus.Done    = 1'b0;
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
      if (i == reset_at) begin
        rstn = 1'b1;
        chk_reset("mid_exec_reset");
        break;
      end
    end
  endtask

  task automatic pin_prog1(input string tag);
    logic [15:0] exp_d [3];
    int          exp_c [3];
    exp_d = '{16'h0040, 16'h0008, 16'h0081};
    exp_c = '{1, 3, 5};
    chk({tag, "_run_count"}, 32'(run_dins.size()), 32'd3);
    for (int i = 0; i < 3 && i < run_dins.size(); i++) begin
      chk($sformatf("%s_run%0d_din", tag, i), 32'(run_dins[i]), 32'(exp_d[i]));
      chk($sformatf("%s_run%0d_cycle", tag, i), 32'(run_cyc[i]), 32'(exp_c[i]));
    end
    chk({tag, "_imm_din"},  32'(din_c2),       32'h0005);
    chk({tag, "_finished"}, 32'(bus.finished), 32'd1);
    chk({tag, "_retired"},  32'(bus.retired),  32'd3);
    chk({tag, "_pc"},       32'(bus.pc),       32'd3);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = 5'd0;
    bus.prog_data = 16'h0000;
    bus.start     = 1'b0;
    bus.last_addr = 5'd0;
    bus.Done      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");
    rstn = 1'b1;

    for (int a = 0; a < DEPTH; a++) load_word(5'(a), 16'h0000);
    load_word(5'd0, 16'h0040);
    load_word(5'd1, 16'h0005);
    load_word(5'd2, 16'h0008);
    load_word(5'd3, 16'h0081);

    // mvi R0,#5; mv R1,R0; add R0,R1
    lat_q = '{1, 1, 3};
    run_trace(5'd3, 1'b0, 1'b0, 1'b0, 16'h0000, -1);
    pin_prog1("prog1");

    // Done never arrives
    lat_q = '{0};
    run_trace(5'd3, 1'b0, 1'b0, 1'b0, 16'h0000, -1);
    chk("timeout_err_cycle", 32'(err_cyc), 32'(TIMEOUT + 2));
    chk("timeout_err_code",  32'(bus.err_code), 32'd1);
    chk("timeout_run_count", 32'(run_dins.size()), 32'd1);

    // mvi as the final word
    lat_q = '{1};
    run_trace(5'd0, 1'b0, 1'b0, 1'b0, 16'h0000, -1);
    chk("trunc_run_count", 32'(run_dins.size()), 32'd0);
    chk("trunc_error",     32'(bus.error),       32'd1);
    chk("trunc_err_code",  32'(bus.err_code),    32'd2);
    chk("trunc_retired",   32'(bus.retired),     32'd0);

    // reset during EXEC of the add, then rerun
    lat_q = '{1, 1, 3};
    run_trace(5'd3, 1'b0, 1'b0, 1'b0, 16'h0000, 6);
    run_trace(5'd3, 1'b0, 1'b0, 1'b0, 16'h0000, -1);
    pin_prog1("rerun");

    // write attempts while busy must not land
    run_trace(5'd3, 1'b0, 1'b1, 1'b0, 16'h0000, -1);
    pin_prog1("wr_busy");
    run_trace(5'd3, 1'b0, 1'b0, 1'b0, 16'h0000, -1);
    pin_prog1("after_wr_busy");

    // five single-word instructions, CW=2 instance saturates
    for (int a = 0; a < 5; a++) load_word(5'(a), 16'h0008);
    lat_q = '{2, 1, 3, 1, 2};
    run_trace(5'd4, 1'b0, 1'b0, 1'b0, 16'h0000, -1);
    chk("sat_retired_cw8", 32'(bus.retired),   32'd5);
    chk("sat_retired_cw2", 32'(bus2.retired),  32'd3);
    chk("sat_finished",    32'(bus2.finished), 32'd1);

    for (int n = 0; n < 30; n++) begin
      logic [15:0] w;
      if (n % 3 == 0) begin
        for (int a = 0; a < DEPTH; a++) begin
          w = 16'($urandom);
          if ($urandom_range(0, 3) == 0) w[8:6] = 3'b001;
          load_word(5'(a), w);
        end
      end
      lat_q.delete();
      for (int k = 0; k < 40; k++) begin
        int r;
        r = $urandom_range(0, 99);
        lat_q.push_back((r < 3) ? 0 : (r < 8) ? TIMEOUT : $urandom_range(1, 5));
      end
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 0) w[8:6] = 3'b001;
      run_trace(5'($urandom_range(0, 31)), 1'b1, 1'b0, 1'($urandom_range(0, 1)), w, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
